alien_hit_scheduler: RTL and testbench



---
 rtl/alien_hit_scheduler.sv | 147 ++++++++++++++
 tb/tb_alien_hit_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alien_hit_scheduler.sv
// Time-multiplexed collision scheduler: one shared bounding-box comparator swept over six aliens per frame.
// Optional `HIT_SCHED_TIMEOUT_EN adds a 15-cycle kill handshake timeout with a sticky kill_err flag.
module alien_hit_scheduler #(
  parameter int GRID_WIDTH       = 40,
  parameter int PROJECTILE_WIDTH = 14
) (
  input  logic       clk_master,
  input  logic       d_reset_n,
  input  logic       frame_tick,
  input  logic [9:0] aliens_x,
  input  logic [9:0] aliens_y,
  input  logic [5:0] alive_in,
  input  logic [9:0] projectile_x,
  input  logic [9:0] projectile_y,
  output logic       kill_valid,
  output logic [2:0] kill_index,
  input  logic       kill_ready,
  output logic       proj_clear,
  output logic       scan_done,
  output logic       busy,
  output logic [7:0] hit_count,
  output logic       kill_err
);

  typedef enum logic [1:0] {IDLE, SCAN, KILL, DONE} state_t;

  localparam logic [9:0] NO_PROJ = 10'h3FF;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [9:0] snap_x, snap_y, snap_px, snap_py;
  logic [5:0] snap_alive;

  logic [1:0]  col;
  logic        row;
  logic        alive_bit;
  logic [10:0] ax, ay, px, py;
  logic        hit;
  logic        accept;
  logic        timeout;

  // Geometry of the alien currently under the comparator; all sums are 11 bits so nothing wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    col       = 2'd0;
    row       = 1'b0;
    alive_bit = 1'b0;
    case (idx)
      3'd0: begin col = 2'd0; row = 1'b0; alive_bit = snap_alive[0]; end
      3'd1: begin col = 2'd1; row = 1'b0; alive_bit = snap_alive[1]; end
      3'd2: begin col = 2'd2; row = 1'b0; alive_bit = snap_alive[2]; end
      3'd3: begin col = 2'd0; row = 1'b1; alive_bit = snap_alive[3]; end
      3'd4: begin col = 2'd1; row = 1'b1; alive_bit = snap_alive[4]; end
      3'd5: begin col = 2'd2; row = 1'b1; alive_bit = snap_alive[5]; end
      default: ;
    endcase
    ax  = {1'b0, snap_x} + 11'(col) * 11'(2 * GRID_WIDTH);
    ay  = {1'b0, snap_y} + (row ? 11'(2 * GRID_WIDTH) : 11'd0);
    px  = {1'b0, snap_px};
    py  = {1'b0, snap_py};
    hit = alive_bit
          && (py > ay) && (py < ay + 11'(GRID_WIDTH))
          && (px + 11'(PROJECTILE_WIDTH) > ax) && (px < ax + 11'(GRID_WIDTH));
  end

  assign kill_valid = (state == KILL);
  assign scan_done  = (state == DONE);
  assign busy       = (state != IDLE);
  assign accept     = (state == KILL) && kill_ready;

`ifdef HIT_SCHED_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       err_q;

  assign timeout  = (state == KILL) && !kill_ready && (wait_cnt == 4'd14);
  assign kill_err = err_q;

  always_ff @(posedge clk_master or negedge d_reset_n) begin
    if (!d_reset_n) begin
      wait_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == KILL && !kill_ready) ? wait_cnt + 4'd1 : 4'd0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout  = 1'b0;
  assign kill_err = 1'b0;
`endif

  always_ff @(posedge clk_master or negedge d_reset_n) begin
    if (!d_reset_n) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (frame_tick) begin
        idx_nxt   = 3'd0;
        state_nxt = (projectile_x == NO_PROJ || projectile_y == NO_PROJ) ? DONE : SCAN;
      end
      SCAN: begin
        if (hit)               state_nxt = KILL;
        else if (idx == 3'd5)  state_nxt = DONE;
        else                   idx_nxt   = idx + 3'd1;
      end
      KILL: if (accept || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot and result registers; the snapshot is cleared on reset so a fresh scan never sees stale data.
  always_ff @(posedge clk_master or negedge d_reset_n) begin
    if (!d_reset_n) begin
      snap_x     <= 10'd0;
      snap_y     <= 10'd0;
      snap_px    <= 10'd0;
      snap_py    <= 10'd0;
      snap_alive <= 6'd0;
      kill_index <= 3'd0;
      proj_clear <= 1'b0;
      hit_count  <= 8'd0;
    end else begin
      if (state == IDLE && frame_tick) begin
        snap_x     <= aliens_x;
        snap_y     <= aliens_y;
        snap_px    <= projectile_x;
        snap_py    <= projectile_y;
        snap_alive <= alive_in;
      end
      if (state == SCAN && hit) kill_index <= idx;
      proj_clear <= accept;
      if (accept && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alien_hit_scheduler.sv
// Directed bench for alien_hit_scheduler: vector table for single scans plus handshake, reset and saturation sequences.
module tb_alien_hit_scheduler;

  logic       clk_master = 1'b0;
  logic       d_reset_n  = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] aliens_x = '0, aliens_y = '0;
  logic [5:0] alive_in = '0;
  logic [9:0] projectile_x = '0, projectile_y = '0;
  logic       kill_ready = 1'b0;
  logic       kill_valid, proj_clear, scan_done, busy, kill_err;
  logic [2:0] kill_index;
  logic [7:0] hit_count;

  int checks   = 0;
  int failures = 0;
  int exp_hits = 0;

  alien_hit_scheduler dut (
    .clk_master   (clk_master),
    .d_reset_n    (d_reset_n),
    .frame_tick   (frame_tick),
    .aliens_x     (aliens_x),
    .aliens_y     (aliens_y),
    .alive_in     (alive_in),
    .projectile_x (projectile_x),
    .projectile_y (projectile_y),
    .kill_valid   (kill_valid),
    .kill_index   (kill_index),
    .kill_ready   (kill_ready),
    .proj_clear   (proj_clear),
    .scan_done    (scan_done),
    .busy         (busy),
    .hit_count    (hit_count),
    .kill_err     (kill_err)
  );

  always #5 clk_master = ~clk_master;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // kv_cyc / done_cyc are cycles after the tick cycle T; kv_cyc = 0 means no kill request.
  typedef struct {
    logic [9:0] ax, ay;
    logic [5:0] alive;
    logic [9:0] px, py;
    int         kv_cyc;
    logic [2:0] k;
    int         done_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic set_inputs(input vec_t v);
    aliens_x     = v.ax;
    aliens_y     = v.ay;
    alive_in     = v.alive;
    projectile_x = v.px;
    projectile_y = v.py;
  endtask

  // Drive a one-cycle tick; returns #1 into cycle T+1.
  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk_master); #1;
    frame_tick = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int kv_first, done_first, pc_cnt, busy_after;
    logic [2:0] idx_seen;
    kv_first = 0; done_first = 0; pc_cnt = 0; busy_after = 1; idx_seen = '0;
    set_inputs(v);
    kill_ready = 1'b1;
    do_tick();
    // Scrambled inputs after the tick: only the snapshot may be used.
    projectile_x = 10'h3FF;
    alive_in     = 6'h00;
    aliens_x     = 10'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_master);
      if (kill_valid && kv_first == 0) begin kv_first = c; idx_seen = kill_index; end
      if (scan_done && done_first == 0) done_first = c;
      if (proj_clear) pc_cnt++;
      if (done_first != 0 && c == done_first + 1) busy_after = int'(busy);
      @(posedge clk_master); #1;
    end
    if (v.kv_cyc != 0) exp_hits++;
    check($sformatf("v%0d kill_valid_cycle", n), kv_first, v.kv_cyc);
    if (v.kv_cyc != 0) check($sformatf("v%0d kill_index", n), 32'(idx_seen), 32'(v.k));
    check($sformatf("v%0d scan_done_cycle", n), done_first, v.done_cyc);
    check($sformatf("v%0d proj_clear_count", n), pc_cnt, (v.kv_cyc != 0) ? 1 : 0);
    check($sformatf("v%0d busy_after_done", n), busy_after, 0);
    check($sformatf("v%0d hit_count", n), 32'(hit_count), exp_hits);
  endtask

  // Assumes the FSM currently holds a kill request.
  task automatic reset_mid_kill();
    check("pre_reset kill_valid", 32'(kill_valid), 1);
    d_reset_n = 1'b0;
    #1;
    check("reset_mid_kill outputs",
          32'({kill_valid, kill_index, proj_clear, scan_done, busy, hit_count, kill_err}), 0);
    @(negedge clk_master);
    d_reset_n = 1'b1;
    exp_hits = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_master);
      check($sformatf("post_reset c%0d pc_busy", c), 32'({proj_clear, busy}), 0);
    end
    @(posedge clk_master); #1;
  endtask

  int kv_cnt, pc_cnt, done_c, stable_cnt, busy_cnt;

  initial begin
    // {ax, ay, alive, px, py, kv_cyc, k, done_cyc}
    vecs[0] = '{10'd144, 10'd134, 6'h3F, 10'd150,  10'd150, 2, 3'd0, 3};
    vecs[1] = '{10'd144, 10'd134, 6'h3F, 10'd230,  10'd220, 6, 3'd4, 7};
    vecs[2] = '{10'd144, 10'd134, 6'h3E, 10'd150,  10'd150, 0, 3'd0, 7};
    vecs[3] = '{10'd144, 10'd134, 6'h3F, 10'h3FF,  10'd150, 0, 3'd0, 1};
    vecs[4] = '{10'd144, 10'd134, 6'h3F, 10'd150,  10'h3FF, 0, 3'd0, 1};
    vecs[5] = '{10'd144, 10'd134, 6'h3F, 10'd300,  10'd220, 7, 3'd5, 8};
    vecs[6] = '{10'd144, 10'd134, 6'h3F, 10'd150,  10'd134, 0, 3'd0, 7};
    vecs[7] = '{10'd144, 10'd134, 6'h3F, 10'd130,  10'd150, 0, 3'd0, 7};
    vecs[8] = '{10'd144, 10'd134, 6'h3F, 10'd183,  10'd173, 2, 3'd0, 3};
    vecs[9] = '{10'd144, 10'd134, 6'h3F, 10'd184,  10'd150, 0, 3'd0, 7};

    #2 d_reset_n = 1'b0;
    #1;
    check("reset outputs",
          32'({kill_valid, kill_index, proj_clear, scan_done, busy, hit_count, kill_err}), 0);
    repeat (2) @(posedge clk_master);
    #1 d_reset_n = 1'b1;
    @(posedge clk_master); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Kill request held against ready low for five cycles, with an ignored tick in the middle.
    set_inputs(vecs[0]);
    kill_ready = 1'b0;
    stable_cnt = 0;
    do_tick();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_master);
      if (c >= 2 && kill_valid && kill_index == 3'd0 && !proj_clear) stable_cnt++;
      @(posedge clk_master); #1;
      frame_tick = (c == 3);
    end
    frame_tick = 1'b0;
    check("hold stable_cycles", stable_cnt, 5);
    kill_ready = 1'b1;
    @(negedge clk_master);
    check("hold handshake kv", 32'({kill_valid, proj_clear}), 32'b10);
    @(posedge clk_master); #1;
    kill_ready = 1'b0;
    exp_hits++;
    @(negedge clk_master);
    check("hold H+1 kv_pc_done", 32'({kill_valid, proj_clear, scan_done}), 32'b011);
    check("hold H+1 hit_count", 32'(hit_count), exp_hits);
    busy_cnt = 0; pc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_master);
      if (busy) busy_cnt++;
      if (proj_clear) pc_cnt++;
    end
    check("hold idle_after busy_cycles", busy_cnt, 0);
    check("hold extra proj_clear", pc_cnt, 0);
    @(posedge clk_master); #1;

`ifdef HIT_SCHED_TIMEOUT_EN
    kill_ready = 1'b0;
    kv_cnt = 0; pc_cnt = 0; done_c = 0;
    do_tick();
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_master);
      if (kill_valid) kv_cnt++;
      if (proj_clear) pc_cnt++;
      if (scan_done && done_c == 0) done_c = c;
      @(posedge clk_master); #1;
    end
    check("timeout kv_cycles", kv_cnt, 15);
    check("timeout done_cycle", done_c, 17);
    check("timeout kill_err", 32'(kill_err), 1);
    check("timeout proj_clear", pc_cnt, 0);
    check("timeout hit_count", 32'(hit_count), exp_hits);
    do_tick();
    repeat (3) @(posedge clk_master);
    #1;
`else
    kill_ready = 1'b0;
    do_tick();
    repeat (20) @(posedge clk_master);
    @(negedge clk_master);
    check("no_timeout kv_held", 32'({kill_valid, kill_err}), 32'b10);
    @(posedge clk_master); #1;
`endif
    reset_mid_kill();

    // Saturation: more accepted kills than the counter can hold.
    set_inputs(vecs[0]);
    kill_ready = 1'b1;
    for (int n = 0; n < 260; n++) begin
      do_tick();
      repeat (5) @(posedge clk_master);
      #1;
    end
    @(negedge clk_master);
    check("hit_count saturation", 32'(hit_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
